// File: rtl/banco_contadores_transicion_pkg.sv
// Shared definitions for the transition-counter bank: edge-mode encodings,
// parameter legality check and the per-mode edge function.
package banco_contadores_transicion_pkg;

  typedef enum logic [1:0] {
    MODO_AMBOS  = 2'd0,
    MODO_SUBIDA = 2'd1,
    MODO_BAJADA = 2'd2
  } modo_e;

  // Used at elaboration time to reject impossible configurations.
  function automatic bit parametros_validos(input int num_cntr, input int ancho,
                                            input int ndir, input int modo);
    return (num_cntr >= 1) && (ancho >= 2) && (ndir >= 1) && (ndir < 31) &&
           ((1 << ndir) >= num_cntr) && (modo >= 0) && (modo <= 2);
  endfunction

  function automatic logic detectar_flanco(input int modo, input logic actual,
                                           input logic previo);
    logic flanco;
    if (modo == int'(MODO_SUBIDA)) begin
      flanco = actual & ~previo;
    end else if (modo == int'(MODO_BAJADA)) begin
      flanco = ~actual & previo;
    end else begin
      flanco = actual ^ previo;
    end
    return flanco;
  endfunction

endpackage

// File: rtl/banco_contadores_transicion_if.sv
// Register/monitor bus of the transition-counter bank; the host drives
// through the master modport, the counter bank sits on the slave modport.
interface banco_contadores_transicion_if #(
  parameter int NUM_CNTR = 3,
  parameter int ANCHO    = 32,
  parameter int NDIR     = 2
);

  logic [NUM_CNTR-1:0] senal;
  logic                habilitar;
  logic                limpiar;
  logic [NDIR-1:0]     dir;
  logic                LE;
  logic                WE;
  logic [ANCHO-1:0]    dato_in;
  logic [ANCHO-1:0]    dato_out;
  logic                dato_valido;
  logic [NUM_CNTR-1:0] desborde;
  logic                error_dir;

  modport master (
    output senal, habilitar, limpiar, dir, LE, WE, dato_in,
    input  dato_out, dato_valido, desborde, error_dir
  );

  modport slave (
    input  senal, habilitar, limpiar, dir, LE, WE, dato_in,
    output dato_out, dato_valido, desborde, error_dir
  );

endinterface

// File: rtl/banco_contadores_transicion_canal.sv
// One channel: edge detector on a monitored signal feeding a saturating,
// preloadable counter with a sticky overflow flag.
module contador_canal
  import banco_contadores_transicion_pkg::*;
#(
  parameter int ANCHO = 32,
  parameter int MODO  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             senal_i,
  input  logic             habilitar_i,
  input  logic             limpiar_i,
  input  logic             carga_i,
  input  logic [ANCHO-1:0] dato_carga_i,
  output logic [ANCHO-1:0] cnt_o,
  output logic             desborde_o
);

  localparam logic [ANCHO-1:0] CNT_MAX = '1;

  logic             prev_q;
  logic [ANCHO-1:0] cnt_q, cnt_d;
  logic             desborde_q, desborde_d;
  logic             flanco;

  // prev follows senal even in reset or when disabled, so stale edges never count.
  always_ff @(posedge clk) begin
    prev_q <= senal_i;
  end

  assign flanco = detectar_flanco(MODO, senal_i, prev_q);

  always_comb begin
    cnt_d      = cnt_q;
    desborde_d = desborde_q;
    if (limpiar_i) begin
      cnt_d      = '0;
      desborde_d = 1'b0;
    end else if (carga_i) begin
      cnt_d      = dato_carga_i;
      desborde_d = 1'b0;
    end else if (habilitar_i && flanco) begin
      if (cnt_q == CNT_MAX) begin
        desborde_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      desborde_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      desborde_q <= desborde_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign desborde_o = desborde_q;

endmodule

// File: rtl/banco_contadores_transicion.sv
// Bank of per-signal transition counters with an addressed read/preload
// port; holds address decode, read mux and the registered outputs.
module banco_contadores_transicion
  import banco_contadores_transicion_pkg::*;
#(
  parameter int NUM_CNTR = 3,
  parameter int ANCHO    = 32,
  parameter int NDIR     = 2,
  parameter int MODO     = 0
) (
  input logic                          clk,
  input logic                          reset,
  banco_contadores_transicion_if.slave bus
);

  generate
    if (!parametros_validos(NUM_CNTR, ANCHO, NDIR, MODO)) begin : g_param_error
      $error("banco_contadores_transicion: illegal NUM_CNTR/ANCHO/NDIR/MODO combination");
    end
  endgenerate

  logic [ANCHO-1:0]    cnt [NUM_CNTR];
  logic [NUM_CNTR-1:0] desborde;
  logic                dir_en_rango;
  logic [ANCHO-1:0]    lectura;

  logic [ANCHO-1:0] dato_out_q, dato_out_d;
  logic             dato_valido_q, dato_valido_d;
  logic             error_dir_q, error_dir_d;

  assign dir_en_rango = (32'(bus.dir) < NUM_CNTR);

  for (genvar i = 0; i < NUM_CNTR; i++) begin : g_canal
    logic carga;
    assign carga = bus.WE && dir_en_rango && (bus.dir == NDIR'(i));

    contador_canal #(
      .ANCHO (ANCHO),
      .MODO  (MODO)
    ) u_canal (
      .clk          (clk),
      .reset        (reset),
      .senal_i      (bus.senal[i]),
      .habilitar_i  (bus.habilitar),
      .limpiar_i    (bus.limpiar),
      .carga_i      (carga),
      .dato_carga_i (bus.dato_in),
      .cnt_o        (cnt[i]),
      .desborde_o   (desborde[i])
    );
  end

  // Read mux sees pre-update counter values; unmatched addresses read as zero.
  always_comb begin
    lectura = '0;
    for (int i = 0; i < NUM_CNTR; i++) begin
      if (bus.dir == NDIR'(i)) begin
        lectura = cnt[i];
      end
    end
  end

  always_comb begin
    dato_out_d    = dato_out_q;
    dato_valido_d = bus.LE;
    error_dir_d   = (bus.LE || bus.WE) && !dir_en_rango;
    if (bus.LE) begin
      dato_out_d = lectura;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dato_out_q    <= '0;
      dato_valido_q <= 1'b0;
      error_dir_q   <= 1'b0;
    end else begin
      dato_out_q    <= dato_out_d;
      dato_valido_q <= dato_valido_d;
      error_dir_q   <= error_dir_d;
    end
  end

  assign bus.dato_out    = dato_out_q;
  assign bus.dato_valido = dato_valido_q;
  assign bus.error_dir   = error_dir_q;
  assign bus.desborde    = desborde;

endmodule

// File: tb/tb_banco_contadores_transicion.sv
// Directed bench: four banks (both/rising/falling edges at 32 bits, both edges
// at 4 bits) share one stimulus stream and are checked against hand tables.
module tb_banco_contadores_transicion;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  senal;
  logic        habilitar, limpiar, le, we;
  logic [1:0]  dir;
  logic [31:0] datoIn;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  banco_contadores_transicion_if #(.NUM_CNTR(3), .ANCHO(32), .NDIR(2)) if0 ();
  banco_contadores_transicion_if #(.NUM_CNTR(3), .ANCHO(32), .NDIR(2)) if1 ();
  banco_contadores_transicion_if #(.NUM_CNTR(3), .ANCHO(32), .NDIR(2)) if2 ();
  banco_contadores_transicion_if #(.NUM_CNTR(3), .ANCHO(4),  .NDIR(2)) if3 ();

  banco_contadores_transicion #(.NUM_CNTR(3), .ANCHO(32), .NDIR(2), .MODO(0))
    dut0 (.clk(clk), .reset(reset), .bus(if0));
  banco_contadores_transicion #(.NUM_CNTR(3), .ANCHO(32), .NDIR(2), .MODO(1))
    dut1 (.clk(clk), .reset(reset), .bus(if1));
  banco_contadores_transicion #(.NUM_CNTR(3), .ANCHO(32), .NDIR(2), .MODO(2))
    dut2 (.clk(clk), .reset(reset), .bus(if2));
  banco_contadores_transicion #(.NUM_CNTR(3), .ANCHO(4),  .NDIR(2), .MODO(0))
    dut3 (.clk(clk), .reset(reset), .bus(if3));

  assign if0.senal = senal;  assign if1.senal = senal;
  assign if2.senal = senal;  assign if3.senal = senal;
  assign if0.habilitar = habilitar;  assign if1.habilitar = habilitar;
  assign if2.habilitar = habilitar;  assign if3.habilitar = habilitar;
  assign if0.limpiar = limpiar;  assign if1.limpiar = limpiar;
  assign if2.limpiar = limpiar;  assign if3.limpiar = limpiar;
  assign if0.dir = dir;  assign if1.dir = dir;  assign if2.dir = dir;  assign if3.dir = dir;
  assign if0.LE = le;  assign if1.LE = le;  assign if2.LE = le;  assign if3.LE = le;
  assign if0.WE = we;  assign if1.WE = we;  assign if2.WE = we;  assign if3.WE = we;
  assign if0.dato_in = datoIn;  assign if1.dato_in = datoIn;
  assign if2.dato_in = datoIn;  assign if3.dato_in = datoIn[3:0];

  logic [31:0] dOut   [4];
  logic        dValid [4];
  logic [2:0]  dDesb  [4];
  logic        dErr   [4];

  assign dOut[0] = if0.dato_out;  assign dOut[1] = if1.dato_out;
  assign dOut[2] = if2.dato_out;  assign dOut[3] = {28'd0, if3.dato_out};
  assign dValid[0] = if0.dato_valido;  assign dValid[1] = if1.dato_valido;
  assign dValid[2] = if2.dato_valido;  assign dValid[3] = if3.dato_valido;
  assign dDesb[0] = if0.desborde;  assign dDesb[1] = if1.desborde;
  assign dDesb[2] = if2.desborde;  assign dDesb[3] = if3.desborde;
  assign dErr[0] = if0.error_dir;  assign dErr[1] = if1.error_dir;
  assign dErr[2] = if2.error_dir;  assign dErr[3] = if3.error_dir;

  typedef struct {
    int          phase;
    logic [1:0]  dir;
    logic [31:0] e0, e1, e2, e3;
  } readVec_t;

  readVec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int d, input logic [31:0] got,
                             input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s dut%0d: got %0h, expected %0h", name, d, got, exp);
    end
  endtask

  // Drives one cycle of strobes, then releases them.
  task automatic applyStimulus(input logic leV, input logic weV, input logic [1:0] dirV,
                               input logic [31:0] dataV);
    le = leV;  we = weV;  dir = dirV;  datoIn = dataV;
    tick();
    le = 1'b0;  we = 1'b0;
  endtask

  task automatic readOne(input string name, input logic [1:0] d, input logic [31:0] e0,
                         input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] exp [4];
    exp[0] = e0;  exp[1] = e1;  exp[2] = e2;  exp[3] = e3;
    applyStimulus(1'b1, 1'b0, d, 32'd0);
    for (int k = 0; k < 4; k++) begin
      checkOutput({name, "_data"}, k, dOut[k], exp[k]);
      checkOutput({name, "_valid"}, k, 32'(dValid[k]), 32'd1);
    end
    checkOutput({name, "_err"}, 0, 32'(dErr[0]), 32'd0);
    tick();
    checkOutput({name, "_valid_drop"}, 0, 32'(dValid[0]), 32'd0);
  endtask

  task automatic runPhase(input int phase);
    for (int v = 0; v < 12; v++) begin
      if (vecs[v].phase == phase) begin
        readOne($sformatf("p%0d_dir%0d", phase, vecs[v].dir), vecs[v].dir,
                vecs[v].e0, vecs[v].e1, vecs[v].e2, vecs[v].e3);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Phase 0 after reset, 1 after toggling senal[1] x10, 2 after limpiar, 3 after preloads.
    vecs[0]  = '{0, 2'd0, 32'd0,  32'd0,  32'd0,  32'd0};
    vecs[1]  = '{0, 2'd1, 32'd0,  32'd0,  32'd0,  32'd0};
    vecs[2]  = '{0, 2'd2, 32'd0,  32'd0,  32'd0,  32'd0};
    vecs[3]  = '{1, 2'd0, 32'd0,  32'd0,  32'd0,  32'd0};
    vecs[4]  = '{1, 2'd1, 32'd10, 32'd5,  32'd5,  32'd10};
    vecs[5]  = '{1, 2'd2, 32'd0,  32'd0,  32'd0,  32'd0};
    vecs[6]  = '{2, 2'd0, 32'd0,  32'd0,  32'd0,  32'd0};
    vecs[7]  = '{2, 2'd1, 32'd0,  32'd0,  32'd0,  32'd0};
    vecs[8]  = '{2, 2'd2, 32'd0,  32'd0,  32'd0,  32'd0};
    vecs[9]  = '{3, 2'd0, 32'd0,  32'd0,  32'd0,  32'd0};
    vecs[10] = '{3, 2'd1, 32'd55, 32'd55, 32'd55, 32'd7};
    vecs[11] = '{3, 2'd2, 32'd0,  32'd0,  32'd0,  32'd0};

    senal = 3'b111;  habilitar = 1'b1;  limpiar = 1'b0;
    le = 1'b0;  we = 1'b0;  dir = 2'd0;  datoIn = 32'd0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput("rst_valid", k, 32'(dValid[k]), 32'd0);
      checkOutput("rst_err", k, 32'(dErr[k]), 32'd0);
      checkOutput("rst_dout", k, dOut[k], 32'd0);
      checkOutput("rst_desb", k, 32'(dDesb[k]), 32'd0);
    end
    repeat (5) tick();
    runPhase(0);

    for (int t = 0; t < 10; t++) begin
      senal[1] = ~senal[1];
      tick();
    end
    runPhase(1);

    // Preload near the top, then three edges on channel 0 (fall, rise, fall).
    applyStimulus(1'b0, 1'b1, 2'd0, 32'hE);
    for (int t = 0; t < 3; t++) begin
      senal[0] = ~senal[0];
      tick();
    end
    readOne("sat_read", 2'd0, 32'h11, 32'hF, 32'h10, 32'hF);
    checkOutput("sat_desb3", 3, 32'(dDesb[3][0]), 32'd1);
    checkOutput("sat_desb0", 0, 32'(dDesb[0][0]), 32'd0);
    applyStimulus(1'b0, 1'b1, 2'd0, 32'd0);
    checkOutput("sat_desb_clr", 3, 32'(dDesb[3][0]), 32'd0);

    // Read, write and a falling edge on channel 2 all in one cycle.
    senal[2] = 1'b0;
    applyStimulus(1'b1, 1'b1, 2'd2, 32'd100);
    for (int k = 0; k < 4; k++) begin
      checkOutput("same_cyc_old", k, dOut[k], 32'd0);
    end
    readOne("same_cyc_new", 2'd2, 32'd100, 32'd100, 32'd100, 32'd4);

    senal = ~senal;
    limpiar = 1'b1;
    tick();
    limpiar = 1'b0;
    runPhase(2);

    applyStimulus(1'b0, 1'b1, 2'd1, 32'd55);
    readOne("pre_oor", 2'd1, 32'd55, 32'd55, 32'd55, 32'd7);
    applyStimulus(1'b1, 1'b0, 2'd3, 32'd0);
    for (int k = 0; k < 4; k++) begin
      checkOutput("oor_rd_data", k, dOut[k], 32'd0);
      checkOutput("oor_rd_valid", k, 32'(dValid[k]), 32'd1);
      checkOutput("oor_rd_err", k, 32'(dErr[k]), 32'd1);
    end
    tick();
    checkOutput("oor_err_pulse", 0, 32'(dErr[0]), 32'd0);
    applyStimulus(1'b0, 1'b1, 2'd3, 32'd77);
    checkOutput("oor_wr_err", 0, 32'(dErr[0]), 32'd1);
    tick();
    runPhase(3);

    // Disabled toggling must not count, including an edge left pending at re-enable.
    habilitar = 1'b0;
    for (int t = 0; t < 4; t++) begin
      senal[0] = ~senal[0];
      tick();
    end
    senal[0] = ~senal[0];
    tick();
    habilitar = 1'b1;
    repeat (3) tick();
    readOne("hab_frozen", 2'd0, 32'd0, 32'd0, 32'd0, 32'd0);

    reset = 1'b1;
    le = 1'b1;  dir = 2'd1;
    tick();
    le = 1'b0;
    checkOutput("rst_mid_valid", 0, 32'(dValid[0]), 32'd0);
    checkOutput("rst_mid_dout", 0, dOut[0], 32'd0);
    reset = 1'b0;
    tick();
    readOne("rst_mid_cleared", 2'd1, 32'd0, 32'd0, 32'd0, 32'd0);
    for (int k = 0; k < 4; k++) begin
      checkOutput("rst_mid_desb", k, 32'(dDesb[k]), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
